md_unit_param: RTL and testbench

Parametrised HI/LO multiply/divide unit for the EX stage of the pipelined MIPS core; successor to the fixed 32-bit md block.
- Widths and multiply latency are parameters.
- Division is a true iterative restoring divider, one quotient bit per cycle.
- Supports abort by exception/eret flush while busy, plus optional multiply-accumulate ops.
- Hazard unit stalls mf*/mt*/md ops while busy or start is high.

---
 rtl/md_pkg.sv | 52 +++++
 rtl/md_div_iter.sv | 74 +++++++
 rtl/md_unit_param.sv | 199 +++++++++++++++++++
 tb/tb_md_unit_param.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// md_pkg: opcodes, FSM state encoding and decode helpers shared by the
// HI/LO multiply/divide unit and its iterative divider.
// Build option: define MD_MACC_EN to decode MADD/MADDU/MSUB/MSUBU as
// multiply-class operations; without it those opcodes behave as NONE.
package md_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

    function automatic logic is_macc(input logic [3:0] op);
        return (op == OP_MADD) || (op == OP_MADDU) ||
               (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
`ifdef MD_MACC_EN
        return (op == OP_MULT) || (op == OP_MULTU) || is_macc(op);
`else
        return (op == OP_MULT) || (op == OP_MULTU);
`endif
    endfunction

    function automatic logic is_md(input logic [3:0] op);
        return is_mul(op) || is_div(op);
    endfunction

    // Operations whose operands are interpreted as two's complement
    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) ||
               (op == OP_MSUB) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/md_div_iter.sv
// md_div_iter: unsigned restoring divider producing one quotient bit per
// step, MSB first. The parent feeds magnitudes and applies signs itself.
// quotient/remainder show the values as they stand after the current step,
// so the parent can commit the final result on the same edge as the last step.
module md_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int SW = $clog2(XLEN + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(XLEN - 1);

    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only when the divisor fits.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, dsr_q};
        quo_d   = quo_q;
        rem_d   = rem_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        if (load) begin
            quo_d = dividend;
            rem_d = '0;
            dsr_d = divisor;
            cnt_d = '0;
        end else if (step) begin
            cnt_d = cnt_q + SW'(1);
            if (trial[XLEN]) begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end else begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end
        end
    end

    // Divider working registers; reset clears any partial division.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
        end
    end

    assign done      = step && (cnt_q == LAST_STEP);
    assign quotient  = quo_d;
    assign remainder = rem_d;

endmodule

// File: rtl/md_unit_param.sv
// md_unit_param: HI/LO multiply/divide unit for the EX stage.
// Multiply is a fixed-latency operation (MUL_LAT busy cycles); divide runs
// the iterative divider for XLEN busy cycles. A flush aborts any operation
// in flight without touching HI/LO.
// Build option: MD_MACC_EN adds the MADD/MADDU/MSUB/MSUBU accumulate path.
module md_unit_param
    import md_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      op,
    input  logic            op_valid,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            flush,
    output logic            start,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int DIV_LAT = XLEN;
    localparam int CNT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MUL_DONE = CW'(MUL_LAT);

    md_state_e       state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic            div_load;
    logic            div_step;
    logic            div_done;
    logic [XLEN-1:0] div_quo;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] dividend_mag;
    logic [XLEN-1:0] divisor_mag;

    logic              mul_signed;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] mul_result;

    logic            quo_neg;
    logic            rem_neg;
    logic [XLEN-1:0] div_lo;
    logic [XLEN-1:0] div_hi;
    logic            div_by_zero;

    assign busy  = (state_q != ST_IDLE);
    assign start = op_valid && is_md(op) && !flush && !busy;
    assign hi    = hi_q;
    assign lo    = lo_q;

    // Operand magnitudes handed to the divider when a divide is issued.
    always_comb begin
        dividend_mag = rs_val;
        divisor_mag  = rt_val;
        if (is_signed_op(op) && rs_val[XLEN-1]) dividend_mag = -rs_val;
        if (is_signed_op(op) && rt_val[XLEN-1]) divisor_mag  = -rt_val;
    end

    md_div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .step     (div_step),
        .dividend (dividend_mag),
        .divisor  (divisor_mag),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    // Full-width product of the latched operands, optionally accumulated
    // onto the current {hi,lo} at completion time.
    always_comb begin
        mul_signed = is_signed_op(op_q);
        a_ext      = mul_signed ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
        b_ext      = mul_signed ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
        product    = a_ext * b_ext;
        mul_result = product;
`ifdef MD_MACC_EN
        if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
            mul_result = {hi_q, lo_q} + product;
        end else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
            mul_result = {hi_q, lo_q} - product;
        end
`endif
    end

    // Sign fix-up of the divider magnitudes: quotient truncates toward zero,
    // remainder follows the dividend's sign.
    always_comb begin
        quo_neg     = (op_q == OP_DIV) && (a_q[XLEN-1] ^ b_q[XLEN-1]);
        rem_neg     = (op_q == OP_DIV) && a_q[XLEN-1];
        div_lo      = quo_neg ? -div_quo : div_quo;
        div_hi      = rem_neg ? -div_rem : div_rem;
        div_by_zero = (b_q == '0);
    end

    // Next-state logic: issue, countdown/completion, abort and mthi/mtlo.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        div_load = 1'b0;
        div_step = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d     = op;
                    a_d      = rs_val;
                    b_d      = rt_val;
                    count_d  = CW'(1);
                    div_load = is_div(op);
                    state_d  = is_div(op) ? ST_DIV : ST_MUL;
                end else if (op_valid && !flush && (op == OP_MTHI)) begin
                    hi_d = rs_val;
                end else if (op_valid && !flush && (op == OP_MTLO)) begin
                    lo_d = rs_val;
                end
            end
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    op_d    = OP_NONE;
                end else if (count_q == MUL_DONE) begin
                    {hi_d, lo_d} = mul_result;
                    state_d      = ST_IDLE;
                    count_d      = '0;
                    op_d         = OP_NONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            ST_DIV: begin
                div_step = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    op_d    = OP_NONE;
                end else if (div_done) begin
                    if (!div_by_zero) begin
                        hi_d = div_hi;
                        lo_d = div_lo;
                    end
                    state_d = ST_IDLE;
                    count_d = '0;
                    op_d    = OP_NONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                op_d    = OP_NONE;
            end
        endcase
    end

    // State and architectural registers; reset discards any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= OP_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_unit_param.sv
// tb_md_unit_param: table of directed operations, hand-written sequences for
// flush/reset/back-to-back corners, then randomized traffic compared cycle by
// cycle against an arithmetic reference model.
module tb_md_unit_param;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic        op_valid;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];

    md_unit_param #(
        .XLEN   (32),
        .MUL_LAT(5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .op_valid(op_valid),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .flush   (flush),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if the design wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic f);
        op_valid = v;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        flush    = f;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic presetHiLo(input logic [31:0] h, input logic [31:0] l);
        applyStimulus(1'b1, OP_MTHI, h, 32'd0, 1'b0);
        step();
        applyStimulus(1'b1, OP_MTLO, l, 32'd0, 1'b0);
        step();
        idle();
    endtask

    task automatic waitIdle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic addVec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ph, input logic [31:0] pl,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int lat, input string name);
        vec_t v;
        v.op = o; v.rs = a; v.rt = b; v.pre_hi = ph; v.pre_lo = pl;
        v.exp_hi = eh; v.exp_lo = el; v.lat = lat; v.name = name;
        vecs.push_back(v);
    endtask

    // Reference decode: which opcodes occupy the unit.
    function automatic logic modelIsMd(input logic [3:0] o);
`ifdef MD_MACC_EN
        return (o >= OP_MULT && o <= OP_DIVU) || (o >= OP_MADD && o <= OP_MSUBU);
`else
        return (o >= OP_MULT && o <= OP_DIVU);
`endif
    endfunction

    // Reference arithmetic: {hi,lo} after the operation completes.
    function automatic logic [63:0] refResult(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] acc);
        longint      sp;
        logic [63:0] up;
        int          q;
        int          r;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (o)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_MADD:  return acc + sp;
            OP_MADDU: return acc + up;
            OP_MSUB:  return acc - sp;
            OP_MSUBU: return acc - up;
            OP_DIV: begin
                if (b == 32'd0) return acc;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            default: return acc;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        int          n;
        logic        r;
        logic        v;
        logic        f;
        logic        exp_start;
        logic [3:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] m_hi;
        logic [31:0] m_lo;
        logic [31:0] m_a;
        logic [31:0] m_b;
        logic [3:0]  m_op;
        logic        m_busy;
        int          m_left;

        addVec(OP_MULT,  32'hFFFFFFFE, 32'd3, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, "mult_neg");
        addVec(OP_MULTU, 32'hFFFFFFFE, 32'd3, 0, 0, 32'h00000002, 32'hFFFFFFFA, 5, "multu");
        addVec(OP_MULT,  32'h80000000, 32'h80000000, 0, 0, 32'h40000000, 32'h0, 5, "mult_minmin");
        addVec(OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 32'h80000001, 5, "mult_maxneg1");
        addVec(OP_DIV,   32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32, "div_neg7_2");
        addVec(OP_DIV,   32'd7, 32'hFFFFFFFE, 0, 0, 32'h1, 32'hFFFFFFFD, 32, "div_7_neg2");
        addVec(OP_DIV,   32'd5, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, 32, "div_by_zero");
        addVec(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5, 5, 32'h0, 32'h80000000, 32, "div_min_neg1");
        addVec(OP_DIVU,  32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 32, "divu_100_7");
        addVec(OP_DIVU,  32'hFFFFFFFF, 32'd2, 0, 0, 32'd1, 32'h7FFFFFFF, 32, "divu_max_2");

        // Reset state
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_hi", hi, 0);
        checkOutput("reset_lo", lo, 0);
        checkOutput("reset_start", start, 0);

        // MTHI then MTLO in consecutive idle cycles
        presetHiLo(32'hDEADBEEF, 32'h1);
        checkOutput("mthi", hi, 32'hDEADBEEF);
        checkOutput("mtlo", lo, 32'h1);

        // Directed operation table
        foreach (vecs[i]) begin
            presetHiLo(vecs[i].pre_hi, vecs[i].pre_lo);
            applyStimulus(1'b1, vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b0);
            checkOutput({vecs[i].name, "_start"}, start, 1);
            step();
            idle();
            waitIdle(n);
            checkOutput({vecs[i].name, "_latency"}, n, vecs[i].lat);
            checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end

        // DIVU aborted by flush in busy cycle 10
        presetHiLo(32'h55, 32'h66);
        applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
        step();
        idle();
        repeat (9) step();
        checkOutput("flushdiv_busy_before", busy, 1);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
        step();
        idle();
        checkOutput("flushdiv_busy", busy, 0);
        checkOutput("flushdiv_hi", hi, 32'h55);
        checkOutput("flushdiv_lo", lo, 32'h66);

        // Flush on the completion cycle of a multiply suppresses the write
        presetHiLo(32'h33, 32'h44);
        applyStimulus(1'b1, OP_MULT, 32'd6, 32'd7, 1'b0);
        step();
        idle();
        repeat (4) step();
        checkOutput("flushlast_busy_before", busy, 1);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0, 1'b1);
        step();
        idle();
        checkOutput("flushlast_busy", busy, 0);
        checkOutput("flushlast_hi", hi, 32'h33);
        checkOutput("flushlast_lo", lo, 32'h44);

        // Flush at issue prevents the start
        applyStimulus(1'b1, OP_MULT, 32'd2, 32'd3, 1'b1);
        checkOutput("flushissue_start", start, 0);
        step();
        idle();
        checkOutput("flushissue_busy", busy, 0);
        checkOutput("flushissue_lo", lo, 32'h44);

        // Unknown opcode has no effect
        applyStimulus(1'b1, 4'hF, 32'd1, 32'd1, 1'b0);
        checkOutput("unknown_start", start, 0);
        step();
        idle();
        checkOutput("unknown_busy", busy, 0);
        checkOutput("unknown_hi", hi, 32'h33);

        // MTLO while busy is ignored
        presetHiLo(32'h11, 32'h22);
        applyStimulus(1'b1, OP_DIV, 32'd5, 32'd0, 1'b0);
        step();
        applyStimulus(1'b1, OP_MTLO, 32'hAAAA, 32'd0, 1'b0);
        step();
        idle();
        checkOutput("mtlo_busy_lo", lo, 32'h22);
        waitIdle(n);
        checkOutput("mtlo_busy_remaining", n, 31);
        checkOutput("mtlo_busy_lo_end", lo, 32'h22);
        checkOutput("mtlo_busy_hi_end", hi, 32'h11);

        // Reset in the middle of a multiply
        applyStimulus(1'b1, OP_MULT, 32'd5, 32'd5, 1'b0);
        step();
        idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_hi", hi, 0);
        checkOutput("midreset_lo", lo, 0);

        // Back-to-back multiplies: second held during busy, starts on busy fall
        applyStimulus(1'b1, OP_MULT, 32'd2, 32'd3, 1'b0);
        checkOutput("b2b_first_start", start, 1);
        step();
        applyStimulus(1'b1, OP_MULT, 32'd4, 32'd5, 1'b0);
        checkOutput("b2b_hazard_start", start, 0);
        waitIdle(n);
        checkOutput("b2b_first_latency", n, 5);
        checkOutput("b2b_first_lo", lo, 32'd6);
        checkOutput("b2b_second_start", start, 1);
        step();
        idle();
        waitIdle(n);
        checkOutput("b2b_second_latency", n, 5);
        checkOutput("b2b_second_lo", lo, 32'd20);
        checkOutput("b2b_second_hi", hi, 32'd0);

        // Multiply-accumulate ops
        presetHiLo(32'h0, 32'hFFFFFFFF);
        applyStimulus(1'b1, OP_MADDU, 32'd1, 32'd1, 1'b0);
`ifdef MD_MACC_EN
        checkOutput("maddu_start", start, 1);
        step();
        idle();
        waitIdle(n);
        checkOutput("maddu_latency", n, 5);
        checkOutput("maddu_hi", hi, 32'h1);
        checkOutput("maddu_lo", lo, 32'h0);
        applyStimulus(1'b1, OP_MSUB, 32'd2, 32'd3, 1'b0);
        checkOutput("msub_start", start, 1);
        step();
        idle();
        waitIdle(n);
        checkOutput("msub_hi", hi, 32'h0);
        checkOutput("msub_lo", lo, 32'hFFFFFFFA);
`else
        checkOutput("maddu_start", start, 0);
        step();
        idle();
        checkOutput("maddu_busy", busy, 0);
        checkOutput("maddu_hi", hi, 32'h0);
        checkOutput("maddu_lo", lo, 32'hFFFFFFFF);
`endif

        // Randomized traffic against the reference model
        m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_op = OP_NONE;
        m_busy = 1'b0; m_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                checkOutput("rnd_busy", busy, m_busy);
                checkOutput("rnd_hi", hi, m_hi);
                checkOutput("rnd_lo", lo, m_lo);
            end
            r = (c == 0) || ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 9) < 7);
            o = 4'($urandom_range(0, 15));
            a = pickOperand();
            b = pickOperand();
            f = ($urandom_range(0, 19) == 0);
            reset = r;
            applyStimulus(v, o, a, b, f);
            exp_start = v && modelIsMd(o) && !f && !m_busy;
            checkOutput("rnd_start", start, exp_start);
            if (r) begin
                m_hi = '0; m_lo = '0; m_busy = 1'b0; m_left = 0;
            end else if (m_busy) begin
                if (f) begin
                    m_busy = 1'b0;
                end else if (m_left == 1) begin
                    {m_hi, m_lo} = refResult(m_op, m_a, m_b, {m_hi, m_lo});
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                end
            end else if (exp_start) begin
                m_op = o; m_a = a; m_b = b; m_busy = 1'b1;
                m_left = (o == OP_DIV || o == OP_DIVU) ? 32 : 5;
            end else if (v && !f && o == OP_MTHI) begin
                m_hi = a;
            end else if (v && !f && o == OP_MTLO) begin
                m_lo = a;
            end
            step();
        end
        reset = 1'b0;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
